adrv9001_tdd_sched: RTL and testbench



---
 rtl/adrv9001_tdd_sched.sv | 135 +++++++++++++
 tb/tb_adrv9001_tdd_sched.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/adrv9001_tdd_sched.sv
// adrv9001_tdd_sched: programmable TDD frame scheduler for rx1/rx2/tx1/tx2 enables.
// Define ADRV9001_TDD_SCHED_GUARD_EN to let rx enables mask tx enables and flag the conflict.
module adrv9001_tdd_sched #(
  parameter int CNT_WIDTH = 32,
  parameter int FRM_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   stop,
  input  logic                   trig,
  input  logic                   trig_mode,
  input  logic                   cfg_update,
  input  logic [CNT_WIDTH-1:0]   frame_len,
  input  logic [FRM_WIDTH-1:0]   num_frames,
  input  logic [3:0]             ch_mask,
  input  logic [4*CNT_WIDTH-1:0] on_cnt,
  input  logic [4*CNT_WIDTH-1:0] off_cnt,
  output logic [3:0]             tdd_en,
  output logic                   frame_strobe,
  output logic [FRM_WIDTH-1:0]   frame_cnt,
  output logic                   busy,
  output logic                   done,
  output logic                   guard_err
);
  typedef enum logic [1:0] {IDLE, ARM, RUN} state_t;
  state_t state, state_nx;
  logic [CNT_WIDTH-1:0] count, len_a, len_s, len_eff;
  logic [FRM_WIDTH-1:0] nf_a;
  logic [3:0] mask_a, mask_s, raw, en_nx;
  logic [4*CNT_WIDTH-1:0] on_a, off_a, on_s, off_s;
  logic trig_d, pending, go, run, wrap, last;

  function automatic logic in_win(input logic [CNT_WIDTH-1:0] on, off, c);
    return on < off ? (c >= on && c < off) : (on > off && (c >= on || c < off));
  endfunction

  assign len_eff = len_a < CNT_WIDTH'(2) ? CNT_WIDTH'(2) : len_a;
  assign go = state == IDLE && start && !stop;
  assign run = state == RUN && !stop;
  assign wrap = state == RUN && count == len_eff - CNT_WIDTH'(1);
  assign last = run && wrap && nf_a != '0 && frame_cnt + FRM_WIDTH'(1) == nf_a;
  assign busy = state != IDLE;

  always_comb begin
    state_nx = state;
    if (stop && state != IDLE) state_nx = IDLE;
    else if (go) state_nx = trig_mode ? ARM : RUN;
    else if (state == ARM && trig && !trig_d) state_nx = RUN;
    else if (last) state_nx = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else state <= state_nx;
  end

`ifdef ADRV9001_TDD_SCHED_GUARD_EN
  logic conflict;
  // rx wins: any rx enable suppresses both tx enables for that cycle
  always_comb begin
    raw = '0;
    for (int k = 0; k < 4; k++)
      raw[k] = run & mask_a[k] & in_win(on_a[k*CNT_WIDTH +: CNT_WIDTH], off_a[k*CNT_WIDTH +: CNT_WIDTH], count);
    conflict = |raw[1:0] & |raw[3:2];
    en_nx = |raw[1:0] ? {2'b00, raw[1:0]} : raw;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) guard_err <= 1'b0;
    else if (go) guard_err <= 1'b0;
    else if (conflict) guard_err <= 1'b1;
  end
`else
  always_comb begin
    raw = '0;
    for (int k = 0; k < 4; k++)
      raw[k] = run & mask_a[k] & in_win(on_a[k*CNT_WIDTH +: CNT_WIDTH], off_a[k*CNT_WIDTH +: CNT_WIDTH], count);
    en_nx = raw;
  end

  assign guard_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      frame_cnt <= '0;
      tdd_en <= '0;
      frame_strobe <= 1'b0;
      done <= 1'b0;
      trig_d <= 1'b0;
      pending <= 1'b0;
      len_a <= '0;
      nf_a <= '0;
      mask_a <= '0;
      on_a <= '0;
      off_a <= '0;
      len_s <= '0;
      mask_s <= '0;
      on_s <= '0;
      off_s <= '0;
    end else begin
      trig_d <= trig;
      tdd_en <= en_nx;
      frame_strobe <= run && count == '0;
      done <= last;
      count <= (state == RUN && !wrap) ? count + CNT_WIDTH'(1) : '0;
      // a pending update only survives while the run continues
      pending <= state != IDLE && state_nx != IDLE && (cfg_update || (pending && !wrap));
      if (cfg_update) begin
        len_s <= frame_len;
        mask_s <= ch_mask;
        on_s <= on_cnt;
        off_s <= off_cnt;
      end
      if (go) begin
        len_a <= frame_len;
        nf_a <= num_frames;
        mask_a <= ch_mask;
        on_a <= on_cnt;
        off_a <= off_cnt;
        frame_cnt <= '0;
      end else begin
        if (run && wrap && frame_cnt != '1) frame_cnt <= frame_cnt + FRM_WIDTH'(1);
        if (run && wrap && pending) begin
          len_a <= len_s;
          mask_a <= mask_s;
          on_a <= on_s;
          off_a <= off_s;
        end
      end
    end
  end
endmodule

// File: tb/tb_adrv9001_tdd_sched.sv
// tb_adrv9001_tdd_sched: directed scoreboard bench; expectations are queued per cycle and checked by a monitor.
module tb_adrv9001_tdd_sched;
  localparam int CW = 32;
  localparam int FW = 16;
  typedef logic [3:0][7:0] ofs_t;
  typedef struct {int cyc; logic [23:0] v; string tag;} exp_t;

  logic clk = 0, rst = 1, start = 0, stop = 0, trig = 0, trig_mode = 0, cfg_update = 0;
  logic [CW-1:0] frame_len = '0;
  logic [FW-1:0] num_frames = '0;
  logic [3:0] ch_mask = '0;
  logic [4*CW-1:0] on_cnt = '0, off_cnt = '0;
  logic [3:0] tdd_en;
  logic frame_strobe, busy, done, guard_err;
  logic [FW-1:0] frame_cnt;
  int cyc = 0, n_chk = 0, n_fail = 0, last_cyc = 0;
  exp_t q[$];
  exp_t e;
  logic [23:0] act;

  adrv9001_tdd_sched #(.CNT_WIDTH(CW), .FRM_WIDTH(FW)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .trig(trig), .trig_mode(trig_mode),
    .cfg_update(cfg_update), .frame_len(frame_len), .num_frames(num_frames), .ch_mask(ch_mask),
    .on_cnt(on_cnt), .off_cnt(off_cnt), .tdd_en(tdd_en), .frame_strobe(frame_strobe),
    .frame_cnt(frame_cnt), .busy(busy), .done(done), .guard_err(guard_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    act = {tdd_en, frame_strobe, busy, done, guard_err, frame_cnt};
    while (q.size() != 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      n_chk++;
      if (e.cyc < cyc) begin
        n_fail++;
        $display("FAIL %s cyc %0d: expectation skipped by monitor", e.tag, e.cyc);
      end else if (act !== e.v) begin
        n_fail++;
        $display("FAIL %s cyc %0d: got en=%b str=%b busy=%b done=%b gerr=%b fc=%0d, want en=%b str=%b busy=%b done=%b gerr=%b fc=%0d",
                 e.tag, cyc, act[23:20], act[19], act[18], act[17], act[16], act[15:0],
                 e.v[23:20], e.v[19], e.v[18], e.v[17], e.v[16], e.v[15:0]);
      end
    end
  end

  function automatic void push(int c, logic [3:0] en, logic s, logic bz, logic dn, logic ge, logic [15:0] fc, string t);
    q.push_back('{c, {en, s, bz, dn, ge, fc}, t});
    last_cyc = c;
  endfunction

  function automatic logic w(int on, int off, int c);
    if (on < off) return c >= on && c < off;
    if (on > off) return c >= on || c < off;
    return 1'b0;
  endfunction

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_cyc(int c);
    while (cyc < c) tick(1);
  endtask

  task automatic cfg(int len, int nf, logic [3:0] m, ofs_t on, ofs_t off, logic tm);
    frame_len = CW'(len);
    num_frames = FW'(nf);
    ch_mask = m;
    trig_mode = tm;
    for (int k = 0; k < 4; k++) begin
      on_cnt[k*CW +: CW] = CW'(on[k]);
      off_cnt[k*CW +: CW] = CW'(off[k]);
    end
  endtask

  task automatic go(output int b);
    wait_cyc(last_cyc);
    b = cyc;
    start = 1;
    tick(1);
    start = 0;
  endtask

  // Expected outputs from cycle b+1 on, where the scheduler enters RUN at cycle b+1 with count 0.
  // Frames numbered >= sw use the on2/off2 offsets.
  task automatic exp_run(int b, int len, int nf, int ncyc, logic [3:0] m, ofs_t on, ofs_t off,
                         int sw, ofs_t on2, ofs_t off2, string t);
    int total, r, c, f, fc;
    logic g, s;
    logic [3:0] en;
    total = nf * len;
    g = 0;
    for (int i = 0; i < ncyc; i++) begin
      en = '0;
      s = 0;
      r = i - 1;
      if (i >= 1 && (nf == 0 || i <= total)) begin
        c = r % len;
        f = r / len;
        for (int k = 0; k < 4; k++)
          en[k] = m[k] & (f >= sw ? w(int'(on2[k]), int'(off2[k]), c) : w(int'(on[k]), int'(off[k]), c));
        s = c == 0;
`ifdef ADRV9001_TDD_SCHED_GUARD_EN
        if (en[1:0] != 0) begin
          if (en[3:2] != 0) g = 1;
          en[3:2] = 0;
        end
`endif
      end
      fc = i / len;
      if (nf != 0 && fc > nf) fc = nf;
      push(b + 1 + i, en, s, nf == 0 || i < total, nf != 0 && i == total, g, 16'(fc), t);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int b;
    for (int i = 1; i <= 3; i++) push(i, 4'b0, 0, 0, 0, 0, 16'd0, "reset");
    tick(4);
    rst = 0;
    tick(2);

    // finite run, on==off channel and out-of-frame offsets never fire
    cfg(10, 2, 4'b0111, {8'd0, 8'd12, 8'd3, 8'd2}, {8'd0, 8'd15, 8'd3, 8'd5}, 0);
    go(b);
    exp_run(b, 10, 2, 22, 4'b0111, {8'd0, 8'd12, 8'd3, 8'd2}, {8'd0, 8'd15, 8'd3, 8'd5},
            99, '0, '0, "finite");

    // continuous wrap-around window, start while busy ignored, stop on a wrap cycle
    cfg(8, 0, 4'b0100, {8'd0, 8'd6, 8'd0, 8'd0}, {8'd0, 8'd2, 8'd0, 8'd0}, 0);
    go(b);
    exp_run(b, 8, 0, 24, 4'b0100, {8'd0, 8'd6, 8'd0, 8'd0}, {8'd0, 8'd2, 8'd0, 8'd0},
            99, '0, '0, "wrapwin");
    wait_cyc(b + 10);
    cfg(3, 1, 4'hf, {8'd0, 8'd0, 8'd0, 8'd0}, {8'd1, 8'd1, 8'd1, 8'd1}, 1);
    start = 1;
    tick(1);
    start = 0;
    wait_cyc(b + 24);
    stop = 1;
    tick(1);
    stop = 0;
    push(b + 25, 4'b0, 0, 0, 0, 0, 16'd2, "stop");
    push(b + 26, 4'b0, 0, 0, 0, 0, 16'd2, "stop_hold");

    // trigger-armed start
    cfg(5, 1, 4'b0001, '0, {8'd0, 8'd0, 8'd0, 8'd1}, 1);
    go(b);
    for (int i = 1; i <= 20; i++) push(b + i, 4'b0, 0, 1, 0, 0, 16'd0, "armed");
    wait_cyc(b + 20);
    trig = 1;
    exp_run(b + 20, 5, 1, 7, 4'b0001, '0, {8'd0, 8'd0, 8'd0, 8'd1}, 99, '0, '0, "trigrun");
    tick(3);
    trig = 0;

    // shadow update mid-frame applies at the next boundary
    cfg(16, 0, 4'b0010, {8'd0, 8'd0, 8'd1, 8'd0}, {8'd0, 8'd0, 8'd8, 8'd0}, 0);
    go(b);
    exp_run(b, 16, 0, 40, 4'b0010, {8'd0, 8'd0, 8'd1, 8'd0}, {8'd0, 8'd0, 8'd8, 8'd0},
            1, {8'd0, 8'd0, 8'd4, 8'd0}, {8'd0, 8'd0, 8'd8, 8'd0}, "cfgupd");
    wait_cyc(b + 6);
    cfg(16, 0, 4'b0010, {8'd0, 8'd0, 8'd4, 8'd0}, {8'd0, 8'd0, 8'd8, 8'd0}, 0);
    cfg_update = 1;
    tick(1);
    cfg_update = 0;
    wait_cyc(b + 40);
    stop = 1;
    tick(1);
    stop = 0;
    push(b + 41, 4'b0, 0, 0, 0, 0, 16'd2, "cfgstop");

    // start and stop together in IDLE: stop wins
    wait_cyc(last_cyc);
    cfg(4, 0, 4'b0001, '0, {8'd0, 8'd0, 8'd0, 8'd2}, 0);
    b = cyc;
    start = 1;
    stop = 1;
    tick(1);
    start = 0;
    stop = 0;
    push(b + 1, 4'b0, 0, 0, 0, 0, 16'd2, "startstop");
    push(b + 2, 4'b0, 0, 0, 0, 0, 16'd2, "startstop2");

    // asynchronous reset mid-run
    cfg(10, 0, 4'b0001, '0, {8'd0, 8'd0, 8'd0, 8'd8}, 0);
    go(b);
    exp_run(b, 10, 0, 6, 4'b0001, '0, {8'd0, 8'd0, 8'd0, 8'd8}, 99, '0, '0, "prerst");
    wait_cyc(b + 7);
    rst = 1;
    push(b + 7, 4'b0, 0, 0, 0, 0, 16'd0, "midrst");
    push(b + 8, 4'b0, 0, 0, 0, 0, 16'd0, "midrst2");
    tick(2);
    rst = 0;
    push(b + 9, 4'b0, 0, 0, 0, 0, 16'd0, "postrst");

    // overlapping rx1/tx2 windows (masked and flagged only with the guard build)
    cfg(8, 1, 4'b1001, {8'd2, 8'd0, 8'd0, 8'd0}, {8'd6, 8'd0, 8'd0, 8'd4}, 0);
    go(b);
    exp_run(b, 8, 1, 11, 4'b1001, {8'd2, 8'd0, 8'd0, 8'd0}, {8'd6, 8'd0, 8'd0, 8'd4},
            99, '0, '0, "overlap");

    // frame_len below 2 behaves as 2; a fresh start clears guard_err
    cfg(0, 3, 4'b0001, '0, {8'd0, 8'd0, 8'd0, 8'd1}, 0);
    go(b);
    exp_run(b, 2, 3, 8, 4'b0001, '0, {8'd0, 8'd0, 8'd0, 8'd1}, 99, '0, '0, "shortlen");

    for (int k = 0; k < 200 && q.size() != 0; k++) tick(1);
    if (q.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain: %0d expectations never reached", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
